// File: rtl/uart_tx_frame.sv
// UART transmitter: one parallel word per start request becomes a
// start / LSB-first data / optional parity / stop-bit frame on `out`.
// Bit timing comes from an internal baud divider on the system clock.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                 clk_50mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BaudW     = $clog2(CLKS_PER_BIT);
  localparam bit          HasParity = (PARITY_MODE != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;

  assign tick = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d  = data;
          // Parity is fixed at acceptance so later data changes cannot alter it.
          parity_d = (PARITY_MODE == 1) ? ~^data : ^data;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        baud_d = tick ? '0 : baud_q + 1'b1;
        if (tick) state_d = StData;
      end
      StData: begin
        baud_d = tick ? '0 : baud_q + 1'b1;
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = HasParity ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        baud_d = tick ? '0 : baud_q + 1'b1;
        if (tick) state_d = StStop;
      end
      StStop: begin
        baud_d = tick ? '0 : baud_q + 1'b1;
        if (tick) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart:  out_d = 1'b0;
      StData:   out_d = shift_d[0];
      StParity: out_d = parity_d;
      default:  out_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
